// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies, FSM state encodings and the compute result bundle.
package md_defs;

    localparam int MD_MUL_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF = 10;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MFHI  = 3'd4,
        MD_MFLO  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div_zero;
    } md_result_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mt_op(input logic [2:0] op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational 64-bit multiply/divide result for one mult_div op.
// Flags a zero divisor so the controller can leave HI/LO untouched.
module md_compute
    import md_defs::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output md_result_t  result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] den_s;
    logic [31:0] den_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    // Substituting a divisor of 1 for the zero and 0x80000000/-1 cases
    // yields quot=rs, rem=0, which is exactly the defined overflow result.
    always_comb begin
        div_zero = (rt_val == 32'd0);
        div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
        den_s    = (div_zero || div_ovf) ? 32'd1 : rt_val;
        den_u    = div_zero ? 32'd1 : rt_val;

        prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};

        quot_s = $signed(rs_val) / $signed(den_s);
        rem_s  = $signed(rs_val) % $signed(den_s);
        quot_u = rs_val / den_u;
        rem_u  = rs_val % den_u;
    end

    always_comb begin
        result          = '0;
        result.div_zero = is_div_op(md_op) && div_zero;
        case (md_op)
            MD_MULT: begin
                result.hi = prod_s[63:32];
                result.lo = prod_s[31:0];
            end
            MD_MULTU: begin
                result.hi = prod_u[63:32];
                result.lo = prod_u[31:0];
            end
            MD_DIV: begin
                result.hi = rem_s;
                result.lo = quot_s;
            end
            MD_DIVU: begin
                result.hi = rem_u;
                result.lo = quot_u;
            end
            default: begin
                result.hi = 32'd0;
                result.lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencing controller: busy countdown FSM, HI/LO state,
// MTHI/MTLO write path, MFHI/MFLO read mux and the start/busy stall feed.
module md_unit_ctrl
    import md_defs::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT_DEF,
    parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic        md_start,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

    md_state_e        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [31:0]      pend_hi_reg;
    logic [31:0]      pend_lo_reg;
    logic             pend_zero_reg;

    logic             accept;
    logic             mt_hi_wr;
    logic             mt_lo_wr;
    md_result_t       calc;

    md_compute u_compute (
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .result (calc)
    );

    // Anything presented while busy or squashed by flush is dropped outright.
    assign accept   = start && !flush && !busy_reg;
    assign md_start = accept && (is_mul_op(md_op) || is_div_op(md_op));
    assign mt_hi_wr = accept && (md_op == MD_MTHI);
    assign mt_lo_wr = accept && (md_op == MD_MTLO);

    assign busy     = busy_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign md_rdata = (md_op == MD_MFHI) ? hi_reg : lo_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            hi_reg        <= 32'd0;
            lo_reg        <= 32'd0;
            pend_hi_reg   <= 32'd0;
            pend_lo_reg   <= 32'd0;
            pend_zero_reg <= 1'b0;
        end else begin
            if (mt_hi_wr) begin
                hi_reg <= rs_val;
            end
            if (mt_lo_wr) begin
                lo_reg <= rs_val;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (md_start) begin
                        busy_reg      <= 1'b1;
                        pend_hi_reg   <= calc.hi;
                        pend_lo_reg   <= calc.lo;
                        pend_zero_reg <= calc.div_zero;
                        if (is_mul_op(md_op)) begin
                            state_reg <= ST_MUL;
                            cnt_reg   <= MUL_CNT_INIT;
                        end else begin
                            state_reg <= ST_DIV;
                            cnt_reg   <= DIV_CNT_INIT;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    // Result lands on the edge that ends the final busy cycle.
                    if (cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        if (!pend_zero_reg) begin
                            hi_reg <= pend_hi_reg;
                            lo_reg <= pend_lo_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: latency, arithmetic corner cases,
// flush/MT/MF behaviour and mid-operation reset, with hand-computed results.
module tb_md_unit_ctrl;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        busy;
    logic        md_start;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic allow_busy_start = 1'b0;

    always #5 clk = ~clk;

    md_unit_ctrl #(
        .MUL_LAT (5),
        .DIV_LAT (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .busy     (busy),
        .md_start (md_start),
        .hi       (hi),
        .lo       (lo),
        .md_rdata (md_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // The stall unit must never present start while busy; flag any stray case.
    always @(posedge clk) begin
        if (reset === 1'b1 && start === 1'b1 && busy === 1'b1 && !allow_busy_start)
            check("start_while_busy", 64'(start), 64'd0);
    end

    // Present one op for a single cycle, then count busy cycles (bounded).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, output logic st, output int cycles);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        flush  = fl;
        #1 st = md_start;
        @(negedge clk);
        start  = 1'b0;
        flush  = 1'b0;
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    logic st;
    int   cyc;

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        md_op  = MD_MFLO;
        rs_val = 32'd0;
        rt_val = 32'd0;
        flush  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);

        do_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, st, cyc);
        check("mult_start",  64'(st),  64'd1);
        check("mult_cycles", 64'(cyc), 64'd5);
        check("mult_hi",     64'(hi),  64'hFFFF_FFFF);
        check("mult_lo",     64'(lo),  64'hFFFF_FFF1);

        do_op(MD_DIVU, 32'd7, 32'd2, 1'b0, st, cyc);
        check("divu_cycles", 64'(cyc), 64'd10);
        check("divu_lo",     64'(lo),  64'd3);
        check("divu_hi",     64'(hi),  64'd1);

        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, st, cyc);
        check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

        do_op(MD_MTHI, 32'h11, 32'd0, 1'b0, st, cyc);
        check("mthi_no_start", 64'(st),  64'd0);
        check("mthi_no_busy",  64'(cyc), 64'd0);
        do_op(MD_MTLO, 32'h22, 32'd0, 1'b0, st, cyc);
        check("mt_setup_hi", 64'(hi), 64'h11);
        check("mt_setup_lo", 64'(lo), 64'h22);

        do_op(MD_DIV, 32'd5, 32'd0, 1'b0, st, cyc);
        check("div0_cycles", 64'(cyc), 64'd10);
        check("div0_hi",     64'(hi),  64'h11);
        check("div0_lo",     64'(lo),  64'h22);

        do_op(MD_MULTU, 32'd9, 32'd9, 1'b1, st, cyc);
        check("flush_multu_start", 64'(st),  64'd0);
        check("flush_multu_busy",  64'(cyc), 64'd0);
        check("flush_multu_hi",    64'(hi),  64'h11);
        check("flush_multu_lo",    64'(lo),  64'h22);
        do_op(MD_MTLO, 32'hABCD, 32'd0, 1'b1, st, cyc);
        check("flush_mtlo_lo", 64'(lo), 64'h22);

        do_op(MD_MTHI, 32'h1234, 32'd0, 1'b0, st, cyc);
        check("mthi_hi", 64'(hi), 64'h1234);
        md_op = MD_MFHI;
        #1 check("mfhi_rdata", 64'(md_rdata), 64'h1234);
        md_op = MD_MFLO;
        #1 check("mflo_rdata", 64'(md_rdata), 64'h22);

        // MTHI presented during a MULTU's busy window must be ignored.
        @(negedge clk);
        start  = 1'b1;
        md_op  = MD_MULTU;
        rs_val = 32'h10;
        rt_val = 32'h10;
        @(negedge clk);
        allow_busy_start = 1'b1;
        md_op  = MD_MTHI;
        rs_val = 32'hDEAD;
        #1 check("mthi_busy_start", 64'(md_start), 64'd0);
        @(negedge clk);
        start = 1'b0;
        allow_busy_start = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("mthi_busy_hi", 64'(hi), 64'd0);
        check("mthi_busy_lo", 64'(lo), 64'h100);

        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, st, cyc);
        check("div_ovf_lo", 64'(lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(hi), 64'd0);

        do_op(MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, st, cyc);
        check("divu_big_lo", 64'(lo), 64'd0);
        check("divu_big_hi", 64'(hi), 64'h8000_0000);

        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, st, cyc);
        check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo", 64'(lo), 64'd1);

        // Flush pulse while busy must not shorten or abort the op.
        @(negedge clk);
        start  = 1'b1;
        md_op  = MD_DIVU;
        rs_val = 32'd9;
        rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cyc = 1;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("flush_busy_cycles", 64'(cyc), 64'd10);
        check("flush_busy_lo",     64'(lo),  64'd2);
        check("flush_busy_hi",     64'(hi),  64'd1);

        // Reset asserted in the 3rd busy cycle of a DIV drops the op.
        @(negedge clk);
        start  = 1'b1;
        md_op  = MD_DIV;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_hi",   64'(hi),   64'd0);
        check("midreset_lo",   64'(lo),   64'd0);
        repeat (12) @(negedge clk);
        check("midreset_dropped_lo", 64'(lo), 64'd0);

        do_op(MD_MULT, 32'd2, 32'd3, 1'b0, st, cyc);
        check("post_reset_cycles", 64'(cyc), 64'd5);
        check("post_reset_lo",     64'(lo),  64'd6);
        check("post_reset_hi",     64'(hi),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
